// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU share arbiter.
package alu_pkg;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer,
// wrapping ascending. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!any_valid && valid[idx]) begin
                any_valid   = 1'b1;
                grant[idx]  = 1'b1;
                winner      = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters, one op in flight.
// Optional macro ALU_ARB_OPCHECK_EN: reject SELECT outside FWD/ADD/AND/OR with RSP_ERR.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = 8,
    parameter  int SEL_W   = 3,
    localparam int ID_W    = (NUM_REQ > 2) ? 2 : 1
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    output logic [NUM_REQ-1:0]        REQ_READY,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA1,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA2,
    input  logic [NUM_REQ*SEL_W-1:0]  REQ_SELECT,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [ID_W-1:0]           RSP_ID,
    output logic [DATA_W-1:0]         RSP_RESULT,
    output logic                      RSP_ERR,
    output logic [DATA_W-1:0]         ALU_DATA1,
    output logic [DATA_W-1:0]         ALU_DATA2,
    output logic [SEL_W-1:0]          ALU_SELECT,
    input  logic [DATA_W-1:0]         ALU_RESULT,
    output logic                      BUSY
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] alu_data1_q, alu_data1_d;
    logic [DATA_W-1:0] alu_data2_q, alu_data2_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               any_valid;
    logic [DATA_W-1:0]  win_data1, win_data2;
    logic [SEL_W-1:0]   win_sel;
    logic               op_legal;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .valid     (REQ_VALID),
        .ptr       (ptr_q),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign win_data1 = REQ_DATA1[int'(winner)*DATA_W +: DATA_W];
    assign win_data2 = REQ_DATA2[int'(winner)*DATA_W +: DATA_W];
    assign win_sel   = REQ_SELECT[int'(winner)*SEL_W +: SEL_W];

`ifdef ALU_ARB_OPCHECK_EN
    assign op_legal = (win_sel <= SEL_W'(ALU_OR));
`else
    assign op_legal = 1'b1;
`endif

    // Gated by RESET_N so the grant is also forced low while reset is held.
    assign REQ_READY  = (state_q == IDLE && RESET_N) ? grant : '0;
    assign RSP_VALID  = (state_q == RESP);
    assign BUSY       = (state_q != IDLE);
    assign RSP_ID     = rsp_id_q;
    assign RSP_RESULT = rsp_result_q;
    assign RSP_ERR    = rsp_err_q;
    assign ALU_DATA1  = alu_data1_q;
    assign ALU_DATA2  = alu_data2_q;
    assign ALU_SELECT = alu_sel_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        alu_data1_d  = alu_data1_q;
        alu_data2_d  = alu_data2_q;
        alu_sel_d    = alu_sel_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ptr_d     = ID_W'((int'(winner) + 1) % NUM_REQ);
                    rsp_id_d  = winner;
                    rsp_err_d = !op_legal;
                    // Rejected ops leave the ALU operands untouched.
                    if (op_legal) begin
                        alu_data1_d = win_data1;
                        alu_data2_d = win_data2;
                        alu_sel_d   = win_sel;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = rsp_err_q ? '0 : ALU_RESULT;
                state_d      = RESP;
            end
            RESP: begin
                if (RSP_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
            alu_sel_q    <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            alu_data1_q  <= alu_data1_d;
            alu_data2_q  <= alu_data2_d;
            alu_sel_q    <= alu_sel_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule
